ntt_ctrl: RTL
=============

NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, meaning polynomial length (power of two).
REQ-002 SHALL have parameter LOG_N, default 8, meaning log2(N) and the number of stages.
REQ-003 SHALL have parameter BF_LAT, default 2, meaning butterfly pipeline latency in cycles.
REQ-004 SHALL have clk_i, input, 1 bit, sole clock, rising edge.
REQ-005 SHALL have rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have start_i, input, 1 bit, start request, sampled in IDLE only.
REQ-007 SHALL have mode_i, input, 1 bit: 0 = forward NTT (Cooley-Tukey), 1 = inverse (Gentleman-Sande); latched on start.
REQ-008 SHALL have stall_i, input, 1 bit, suppresses issue of new pairs.
REQ-009 SHALL have busy_o, output, 1 bit, high from start acceptance until done.
REQ-010 SHALL have done_o, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have rd_en_o, rd_addr_a_o, rd_addr_b_o, outputs, 1/LOG_N/LOG_N bits, coefficient RAM read port.
REQ-012 SHALL have twiddle_idx_o, output, LOG_N bits, twiddle ROM index.
REQ-013 SHALL have sel_butterfly_o and sel_red_o, outputs, 1 bit each, butterfly configuration.
REQ-014 SHALL have wr_en_o, wr_addr_a_o, wr_addr_b_o, outputs, 1/LOG_N/LOG_N bits, coefficient RAM write port.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DRAIN -> (RUN | DONE) -> IDLE.
REQ-016 SHALL move IDLE->RUN when start_i=1; start_i in any other state ignored.
REQ-017 SHALL issue one pair per RUN cycle with stall_i=0: pair counter j = 0..N/2-1; stall_i=1 holds j, rd_en_o=0.
REQ-018 SHALL use stage length len = N>>(s+1) for mode 0, len = 1<<s for mode 1, stage s = 0..LOG_N-1.
REQ-019 SHALL compute group g = j/len, offset o = j%len, rd_addr_a_o = 2*len*g + o, rd_addr_b_o = rd_addr_a_o + len.
REQ-020 SHALL drive twiddle_idx_o = (N/2)/len + g for both modes, aligned with read address.
REQ-021 SHALL drive sel_butterfly_o = latched mode; sel_red_o = 1 only in mode 1, last stage; both 0 in IDLE.
REQ-022 SHALL assert wr_en_o with the issuing pair's addresses exactly BF_LAT+1 cycles after rd_en_o (1-cycle RAM read plus butterfly).
REQ-023 SHALL enter DRAIN after the last pair of a stage and hold issue for BF_LAT+1 cycles, preventing read-after-write hazard.
REQ-024 SHALL, at DRAIN end, advance s and return to RUN, or after stage LOG_N-1 go to DONE.
REQ-025 SHALL pulse done_o for the single DONE cycle, deassert busy_o the same cycle, return to IDLE next cycle.
REQ-026 SHALL, with no stall, take LOG_N*(N/2+BF_LAT+1) cycles from start acceptance to done_o (1048 at defaults).
REQ-027 SHALL allow start_i in the cycle after done_o to begin a new transform.

Reset
REQ-028 SHALL, on rst_ni=0 at any time, clear state to IDLE, j, s, delay line and all outputs to 0 immediately.
REQ-029 SHALL discard in-flight writes on reset mid-operation; no wr_en_o after reset release until a new start.

Structure
REQ-030 SHALL place N, LOG_N, modulus Q = 8380417 and the FSM state enum in shared package ntt_pkg.
REQ-031 SHALL implement write-address/enable alignment in one sub-module ntt_delay_line (depth BF_LAT+1, width 2*LOG_N+1).

Verification
REQ-032 SHALL test: reset, start mode 0 -> first cycle rd_addr 0/128, twiddle 1; j=127 of stage 0 -> 127/255.
REQ-033 SHALL test: mode 0 stage 1, j=64 -> rd_addr 128/192, twiddle 3; stage 7 j=5 -> 10/11, twiddle 133.
REQ-034 SHALL test: mode 1 stage 0 j=3 -> rd_addr 6/7, twiddle 131; last stage sel_red_o=1, earlier 0.
REQ-035 SHALL test: no stall -> done_o exactly 1048 cycles after start; wr_en_o count = 1024 with matching addresses.
REQ-036 SHALL test: stall_i high 10 cycles mid-stage -> done delayed by 10, address sequence unchanged.
REQ-037 SHALL test: rst_ni low mid stage 3 -> all outputs 0, busy_o=0, then fresh start completes correctly.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state encoding for the NTT address/sequence controller.
package ntt_pkg;

    localparam int unsigned NTT_N     = 32'd256;
    localparam int unsigned NTT_LOG_N = 32'd8;
    localparam int unsigned NTT_Q     = 32'd8380417;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth register pipeline that carries read enable/addresses forward
// so writes land on the same pair once the RAM read and butterfly have completed.
module ntt_delay_line #(
    parameter int unsigned DEPTH = 32'd3,
    parameter int unsigned WIDTH = 32'd17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift register; reset flushes any in-flight write request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// NTT stage/pair sequencer: walks LOG_N stages of N/2 butterflies, generating
// RAM read/write addresses, twiddle indices and butterfly configuration.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned N      = NTT_N,
    parameter int unsigned LOG_N  = NTT_LOG_N,
    parameter int unsigned BF_LAT = 32'd2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             stall_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [LOG_N-1:0] rd_addr_a_o,
    output logic [LOG_N-1:0] rd_addr_b_o,
    output logic [LOG_N-1:0] twiddle_idx_o,
    output logic             sel_butterfly_o,
    output logic             sel_red_o,
    output logic             wr_en_o,
    output logic [LOG_N-1:0] wr_addr_a_o,
    output logic [LOG_N-1:0] wr_addr_b_o
);

    localparam int unsigned     SW         = (LOG_N > 32'd1) ? $clog2(LOG_N) : 32'd1;
    localparam int unsigned     DW         = $clog2(BF_LAT + 32'd2);
    localparam logic [LOG_N-1:0] HALF_N     = LOG_N'(N / 32'd2);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 32'd1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(BF_LAT);

    ntt_state_e       state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [LOG_N-1:0] j_q, j_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sel_bf_q, sel_bf_d;
    logic             sel_red_q, sel_red_d;

    logic             rd_en_q;
    logic [LOG_N-1:0] rd_a_q, rd_b_q, tw_q;

    logic             issue_s;
    logic             iss_mode_s;
    logic [SW-1:0]    iss_stage_s;
    logic [LOG_N-1:0] iss_j_s;

    logic [LOG_N-1:0] lg_s, len_s, grp_s, off_s;
    logic [LOG_N-1:0] addr_a_s, addr_b_s, tw_s;
    logic [2*LOG_N:0] wr_bus_s;

    // Pair addressing: len is a power of two, so divide/modulo reduce to shift/mask.
    always_comb begin
        lg_s     = iss_mode_s ? LOG_N'(iss_stage_s)
                              : (LOG_N'(LOG_N - 32'd1) - LOG_N'(iss_stage_s));
        len_s    = LOG_N'(1) << lg_s;
        grp_s    = iss_j_s >> lg_s;
        off_s    = iss_j_s & (len_s - LOG_N'(1));
        addr_a_s = (grp_s << (lg_s + LOG_N'(1))) | off_s;
        addr_b_s = addr_a_s + len_s;
        tw_s     = (LOG_N'(1) << (LOG_N'(LOG_N - 32'd1) - lg_s)) + grp_s;
    end

    // Next-state logic; entering RUN issues pair 0 in the same edge so no cycle is lost.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        j_d         = j_q;
        drain_d     = drain_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sel_bf_d    = sel_bf_q;
        sel_red_d   = sel_red_q;
        issue_s     = 1'b0;
        iss_mode_s  = mode_q;
        iss_stage_s = stage_q;
        iss_j_s     = j_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_RUN;
                    mode_d      = mode_i;
                    stage_d     = {SW{1'b0}};
                    busy_d      = 1'b1;
                    sel_bf_d    = mode_i;
                    sel_red_d   = mode_i & (LAST_STAGE == {SW{1'b0}});
                    iss_mode_s  = mode_i;
                    iss_stage_s = {SW{1'b0}};
                    iss_j_s     = {LOG_N{1'b0}};
                    issue_s     = ~stall_i;
                    j_d         = issue_s ? LOG_N'(1) : {LOG_N{1'b0}};
                end else begin
                    busy_d    = 1'b0;
                    sel_bf_d  = 1'b0;
                    sel_red_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (j_q == HALF_N) begin
                    state_d = ST_DRAIN;
                    drain_d = {DW{1'b0}};
                end else if (!stall_i) begin
                    issue_s = 1'b1;
                    j_d     = j_q + LOG_N'(1);
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = ST_RUN;
                        stage_d     = stage_q + SW'(1);
                        sel_red_d   = mode_q & (stage_d == LAST_STAGE);
                        iss_stage_s = stage_d;
                        iss_j_s     = {LOG_N{1'b0}};
                        issue_s     = ~stall_i;
                        j_d         = issue_s ? LOG_N'(1) : {LOG_N{1'b0}};
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                sel_bf_d  = 1'b0;
                sel_red_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                sel_bf_d  = 1'b0;
                sel_red_d = 1'b0;
            end
        endcase
    end

    // FSM state and all externally visible read-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            stage_q   <= {SW{1'b0}};
            j_q       <= {LOG_N{1'b0}};
            drain_q   <= {DW{1'b0}};
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_bf_q  <= 1'b0;
            sel_red_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_a_q    <= {LOG_N{1'b0}};
            rd_b_q    <= {LOG_N{1'b0}};
            tw_q      <= {LOG_N{1'b0}};
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            j_q       <= j_d;
            drain_q   <= drain_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_bf_q  <= sel_bf_d;
            sel_red_q <= sel_red_d;
            rd_en_q   <= issue_s;
            if (issue_s) begin
                rd_a_q <= addr_a_s;
                rd_b_q <= addr_b_s;
                tw_q   <= tw_s;
            end else begin
                rd_a_q <= rd_a_q;
                rd_b_q <= rd_b_q;
                tw_q   <= tw_q;
            end
        end
    end

    ntt_delay_line #(
        .DEPTH (BF_LAT + 32'd1),
        .WIDTH (32'd2 * LOG_N + 32'd1)
    ) u_wr_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({rd_en_q, rd_a_q, rd_b_q}),
        .q_o    (wr_bus_s)
    );

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign rd_en_o         = rd_en_q;
    assign rd_addr_a_o     = rd_a_q;
    assign rd_addr_b_o     = rd_b_q;
    assign twiddle_idx_o   = tw_q;
    assign sel_butterfly_o = sel_bf_q;
    assign sel_red_o       = sel_red_q;
    assign wr_en_o         = wr_bus_s[2*LOG_N];
    assign wr_addr_a_o     = wr_bus_s[2*LOG_N-1:LOG_N];
    assign wr_addr_b_o     = wr_bus_s[LOG_N-1:0];

endmodule
